// File: rtl/scrambler_2_pkg.sv
// scrambler_2 shared definitions: FSM state encoding, LFSR step
// function and the default address/size/seed constants.
package scrambler_2_pkg;

    localparam logic [15:0] BASE_ADDR = 16'hF050;
    localparam int          DEPTH     = 32;
    localparam logic [7:0]  SEED      = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // 8-bit Fibonacci LFSR, taps 7,5,4,3, shifting toward the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/scrambler_2_ram.sv
// scrambler_2 32x8 byte buffer.
// Ports: clk, rst_n; one write port (we/waddr/wdata); a registered
// user read port (r_ok/r_addr -> dout, 00 when r_ok is low); a
// registered FSM read port (f_rd/f_addr -> f_q).
module scrambler_2_ram
    import scrambler_2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic       r_ok,
    input  logic [4:0] r_addr,
    output logic [7:0] dout,
    input  logic       f_rd,
    input  logic [4:0] f_addr,
    output logic [7:0] f_q
);

    logic [7:0] mem [DEPTH];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (f_rd)
            f_q <= mem[f_addr];
    end

    // Nonblocking read of mem gives read-before-write on a same-cycle hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= 8'h00;
        else
            dout <= r_ok ? mem[r_addr] : 8'h00;
    end

endmodule

// File: rtl/scrambler_2.sv
// scrambler_2 top: in-place LFSR XOR scrambler over a 32-byte buffer.
// Ports: clk, rst_n, start, len_1 (bytes-1), usr_r_addr, usr_w_addr,
// usr_din, usr_wr_en; outputs busy and registered read data dout.
module scrambler_2
    import scrambler_2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  len_1,
    input  logic [15:0] usr_r_addr,
    input  logic [15:0] usr_w_addr,
    input  logic [7:0]  usr_din,
    input  logic        usr_wr_en,
    output logic        busy,
    output logic [7:0]  dout
);

    state_t      state, state_nx;
    logic [4:0]  idx;
    logic [4:0]  len_q;
    logic [7:0]  lfsr;
    logic [15:0] r_off, w_off;
    logic        r_ok, w_ok;
    logic        last;
    logic        f_rd, f_wr;
    logic        we;
    logic [4:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  f_q;

    // Below-base addresses wrap to large offsets and fail the check
    assign r_off = usr_r_addr - BASE_ADDR;
    assign w_off = usr_w_addr - BASE_ADDR;
    assign r_ok  = (r_off[15:5] == 11'd0);
    assign w_ok  = (w_off[15:5] == 11'd0);
    assign last  = (idx == len_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RD;
            RD:   state_nx = WR;
            WR:   state_nx = last ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        f_rd = 1'b0;
        f_wr = 1'b0;
        unique case (state)
            IDLE: ;
            RD: begin
                busy = 1'b1;
                f_rd = 1'b1;
            end
            WR: begin
                busy = 1'b1;
                f_wr = 1'b1;
            end
            default: ;
        endcase
    end

    // Index, length latch and keystream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= 5'd0;
            len_q <= 5'd0;
            lfsr  <= SEED;
        end else if (state == IDLE) begin
            if (start) begin
                idx   <= 5'd0;
                len_q <= len_1;
                lfsr  <= SEED;
            end
        end else if (f_wr) begin
            lfsr <= lfsr_next(lfsr);
            if (!last)
                idx <= idx + 5'd1;
        end
    end

    // FSM write has priority; user writes only land while idle
    always_comb begin
        we    = 1'b0;
        waddr = w_off[4:0];
        wdata = usr_din;
        if (f_wr) begin
            we    = 1'b1;
            waddr = idx;
            wdata = f_q ^ lfsr;
        end else if (usr_wr_en && w_ok && !busy) begin
            we = 1'b1;
        end
    end

    scrambler_2_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .r_ok   (r_ok),
        .r_addr (r_off[4:0]),
        .dout   (dout),
        .f_rd   (f_rd),
        .f_addr (idx),
        .f_q    (f_q)
    );

endmodule

// File: tb/tb_scrambler_2.sv
// Directed self-checking bench for scrambler_2.
// Keeps a byte model of the buffer and checks reads and busy length.
module tb_scrambler_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  len_1 = 5'd0;
    logic [15:0] usr_r_addr = 16'h0000;
    logic [15:0] usr_w_addr = 16'h0000;
    logic [7:0]  usr_din = 8'h00;
    logic        usr_wr_en = 1'b0;
    logic        busy;
    logic [7:0]  dout;

    int n_chk = 0;
    int n_ok  = 0;
    logic [7:0] m [32];
    logic [7:0] rd;
    int nb;

    always #5 clk = ~clk;

    scrambler_2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len_1      (len_1),
        .usr_r_addr (usr_r_addr),
        .usr_w_addr (usr_w_addr),
        .usr_din    (usr_din),
        .usr_wr_en  (usr_wr_en),
        .busy       (busy),
        .dout       (dout)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_ok++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // keystream byte k: SEED stepped k times
    function automatic logic [7:0] ks(input int k);
        logic [7:0] s;
        s = 8'hFF;
        for (int i = 0; i < k; i++)
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        usr_w_addr = a;
        usr_din    = d;
        usr_wr_en  = 1'b1;
        tick();
        usr_wr_en  = 1'b0;
    endtask

    task automatic rdb(input logic [15:0] a, output logic [7:0] d);
        usr_r_addr = a;
        tick();
        d = dout;
    endtask

    // start a pass, optionally poke a dropped write and an extra start,
    // then count busy cycles
    task automatic run(input logic [4:0] l, input bit poke, output int n);
        len_1 = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (poke && n == 2) begin
                usr_w_addr = 16'hF050;
                usr_din    = 8'hAA;
                usr_wr_en  = 1'b1;
                start      = 1'b1;
                len_1      = 5'd31;
            end
            tick();
            usr_wr_en = 1'b0;
            start     = 1'b0;
        end
        for (int k = 0; k <= int'(l); k++)
            m[k] = m[k] ^ ks(k);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 8'h00);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            m[i] = 8'(i + 1);
            wr(16'hF050 + 16'(i), m[i]);
        end
        for (int i = 0; i < 10; i++) begin
            rdb(16'hF050 + 16'(i), rd);
            check($sformatf("rd%0d", i), rd, i + 1);
        end

        // same-cycle read and write of one offset returns old data
        usr_r_addr = 16'hF053;
        wr(16'hF053, 8'h77);
        check("rbw_old", dout, 8'h04);
        rdb(16'hF053, rd);
        check("rbw_new", rd, 8'h77);
        wr(16'hF053, 8'h04);

        run(5'd9, 1'b1, nb);
        check("busy9", nb, 20);
        rdb(16'hF050, rd);
        check("s0", rd, 8'hFE);
        rdb(16'hF051, rd);
        check("s1", rd, 8'hFC);
        rdb(16'hF052, rd);
        check("s2", rd, 8'hFF);
        for (int i = 3; i < 11; i++) begin
            rdb(16'hF050 + 16'(i), rd);
            check($sformatf("s%0d", i), rd, m[i]);
        end
        check("s10_keep", m[10], 8'h0B);

        rdb(16'hF04F, rd);
        check("lo_oob", rd, 8'h00);
        rdb(16'hF06F, rd);
        check("top_ok", rd, m[31]);
        rdb(16'hF070, rd);
        check("hi_oob", rd, 8'h00);
        wr(16'hF070, 8'h5A);
        rdb(16'hF050, rd);
        check("oob_wr", rd, 8'hFE);

        run(5'd0, 1'b0, nb);
        check("busy0", nb, 2);
        rdb(16'hF050, rd);
        check("l0_b0", rd, 8'h01);
        rdb(16'hF051, rd);
        check("l0_b1", rd, 8'hFC);
        run(5'd0, 1'b0, nb);
        rdb(16'hF050, rd);
        check("l0_undo", rd, 8'hFE);

        run(5'd31, 1'b0, nb);
        check("busy31", nb, 64);
        for (int i = 0; i < 32; i++) begin
            rdb(16'hF050 + 16'(i), rd);
            check($sformatf("f%0d", i), rd, m[i]);
        end

        // abort after bytes 0 and 1 have been written back
        usr_r_addr = 16'hF052;
        len_1 = 5'd31;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("mid_busy", busy, 1);
        check("mid_dout", dout, m[2]);
        rst_n = 1'b0;
        #1;
        check("ab_busy", busy, 0);
        check("ab_dout", dout, 8'h00);
        m[0] = m[0] ^ ks(0);
        m[1] = m[1] ^ ks(1);
        tick();
        rst_n = 1'b1;
        tick();
        run(5'd1, 1'b0, nb);
        check("re_busy", nb, 4);
        for (int i = 0; i < 3; i++) begin
            rdb(16'hF050 + 16'(i), rd);
            check($sformatf("re%0d", i), rd, m[i]);
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
